uv_nb_ctx: RTL and testbench

//  Chroma neighbour-context stage: sits upstream of the chroma mode picker (feeds top/left/top-left
//  U,V samples) and downstream of it (consumes the chosen 8x8 U+V reconstruction). Keeps a top line

---
 rtl/uv_nb_ctx_pkg.sv | 29 ++
 rtl/uv_nb_ctx_if.sv | 33 +++
 rtl/uv_top_line_ram.sv | 32 +++
 rtl/uv_nb_ctx.sv | 204 ++++++++++++++++++++
 tb/tb_uv_nb_ctx.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uv_nb_ctx_pkg.sv
// Shared constants, FSM encoding and U/V byte-index helpers for the chroma
// neighbour-context stage.
package uv_nb_ctx_pkg;

  localparam logic [7:0] FILL_TOP  = 8'd127;
  localparam logic [7:0] FILL_LEFT = 8'd129;
  localparam int         COORD_W   = 10;
  localparam int         LINE_W    = 128;
  localparam int         REC_W     = 1024;

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_RD    = 6'b000010,
    S_LATCH = 6'b000100,
    S_CDONE = 6'b001000,
    S_WR    = 6'b010000,
    S_UDONE = 6'b100000
  } state_e;

  // Byte index of U(r,c) / V(r,c) inside the 1024-bit reconstruction bus.
  function automatic int u_byte(input int r, input int c);
    return r * 8 + c;
  endfunction

  function automatic int v_byte(input int r, input int c);
    return 64 + r * 8 + c;
  endfunction

endpackage

// File: rtl/uv_nb_ctx_if.sv
// Request/response bundle between the chroma mode picker and the
// neighbour-context stage.
interface uv_nb_ctx_if;
  import uv_nb_ctx_pkg::*;

  logic                ctx_start;
  logic                upd_start;
  logic [COORD_W-1:0]  x;
  logic [COORD_W-1:0]  y;
  logic [REC_W-1:0]    rec_uv;
  logic [63:0]         top_u;
  logic [63:0]         top_v;
  logic [63:0]         left_u;
  logic [63:0]         left_v;
  logic [7:0]          top_left_u;
  logic [7:0]          top_left_v;
  logic                ctx_done;
  logic                upd_done;
  logic                busy;

  modport master (
    output ctx_start, upd_start, x, y, rec_uv,
    input  top_u, top_v, left_u, left_v, top_left_u, top_left_v,
    input  ctx_done, upd_done, busy
  );

  modport slave (
    input  ctx_start, upd_start, x, y, rec_uv,
    output top_u, top_v, left_u, left_v, top_left_u, top_left_v,
    output ctx_done, upd_done, busy
  );

endinterface

// File: rtl/uv_top_line_ram.sv
// Simple dual-port top line buffer: one word per MB column, registered read.
module uv_top_line_ram #(
  parameter int MAX_MB_W = 64,
  parameter int AW       = 6,
  parameter int W        = 128
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [0:MAX_MB_W-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/uv_nb_ctx.sv
// Chroma neighbour-context stage: builds top/left/top-left U,V context with
// frame-edge fill and absorbs chosen reconstructions into the line buffer.
module uv_nb_ctx
  import uv_nb_ctx_pkg::*;
#(
  parameter int MAX_MB_W = 64,
  parameter int AW       = 6
) (
  input logic        clk,
  input logic        rst_n,
  uv_nb_ctx_if.slave nb
);

  state_e              state_q, state_d;
  logic                pending_q, pending_d;
  logic [COORD_W-1:0]  ctx_x_q, ctx_y_q, upd_x_q;
  logic [63:0]         top_u_q, top_v_q, left_u_q, left_v_q;
  logic [63:0]         top_u_d, top_v_d, left_u_d, left_v_d;
  logic [7:0]          tl_u_q, tl_v_q, tl_u_d, tl_v_d;
  logic                cap_ctx_s, cap_upd_s, ram_re_s, ram_we_s, ld_ctx_s, ld_upd_s;
  logic [LINE_W-1:0]   ram_rdata_s, ram_wdata_s;
  logic [63:0]         col_u_s, col_v_s;
  logic                ctx_oob_s, upd_oob_s;

  assign ctx_oob_s = (ctx_x_q >= COORD_W'(MAX_MB_W));
  assign upd_oob_s = (upd_x_q >= COORD_W'(MAX_MB_W));

  // FSM next-state and control strobes
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cap_ctx_s = 1'b0;
    cap_upd_s = 1'b0;
    ram_re_s  = 1'b0;
    ram_we_s  = 1'b0;
    ld_ctx_s  = 1'b0;
    ld_upd_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (nb.upd_start) begin
          cap_upd_s = 1'b1;
          state_d   = S_WR;
          if (nb.ctx_start) begin
            cap_ctx_s = 1'b1;
            pending_d = 1'b1;
          end else begin
            pending_d = 1'b0;
          end
        end else if (nb.ctx_start) begin
          cap_ctx_s = 1'b1;
          state_d   = S_RD;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_RD: begin
        ram_re_s = 1'b1;
        state_d  = S_LATCH;
      end
      S_LATCH: begin
        ld_ctx_s = 1'b1;
        state_d  = S_CDONE;
      end
      S_CDONE: begin
        state_d = S_IDLE;
      end
      S_WR: begin
        ram_we_s = ~upd_oob_s;
        ld_upd_s = 1'b1;
        state_d  = S_UDONE;
        if (nb.ctx_start) begin
          cap_ctx_s = 1'b1;
          pending_d = 1'b1;
        end else begin
          pending_d = pending_q;
        end
      end
      S_UDONE: begin
        pending_d = 1'b0;
        if (pending_q || nb.ctx_start) begin
          cap_ctx_s = nb.ctx_start;
          state_d   = S_RD;
        end else begin
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  // Bottom row goes to the line buffer, rightmost column becomes the next left context
  always_comb begin
    ram_wdata_s = '0;
    col_u_s     = '0;
    col_v_s     = '0;
    for (int i = 0; i < 8; i++) begin
      ram_wdata_s[8*i +: 8]      = nb.rec_uv[8*u_byte(7, i) +: 8];
      ram_wdata_s[64 + 8*i +: 8] = nb.rec_uv[8*v_byte(7, i) +: 8];
      col_u_s[8*i +: 8]          = nb.rec_uv[8*u_byte(i, 7) +: 8];
      col_v_s[8*i +: 8]          = nb.rec_uv[8*v_byte(i, 7) +: 8];
    end
  end

  // Output register next values with frame-edge fill
  always_comb begin
    top_u_d  = top_u_q;
    top_v_d  = top_v_q;
    left_u_d = left_u_q;
    left_v_d = left_v_q;
    tl_u_d   = tl_u_q;
    tl_v_d   = tl_v_q;
    if (ld_ctx_s) begin
      if ((ctx_y_q == COORD_W'(0)) || ctx_oob_s) begin
        top_u_d = {8{FILL_TOP}};
        top_v_d = {8{FILL_TOP}};
      end else begin
        top_u_d = ram_rdata_s[63:0];
        top_v_d = ram_rdata_s[127:64];
      end
      if (ctx_x_q == COORD_W'(0)) begin
        left_u_d = {8{FILL_LEFT}};
        left_v_d = {8{FILL_LEFT}};
        tl_u_d   = (ctx_y_q == COORD_W'(0)) ? FILL_TOP : FILL_LEFT;
        tl_v_d   = (ctx_y_q == COORD_W'(0)) ? FILL_TOP : FILL_LEFT;
      end else if (ctx_y_q == COORD_W'(0)) begin
        tl_u_d = FILL_TOP;
        tl_v_d = FILL_TOP;
      end else begin
        tl_u_d = tl_u_q;
        tl_v_d = tl_v_q;
      end
    end else if (ld_upd_s) begin
      // The top row seen by this MB supplies the corner of the MB to its right.
      left_u_d = col_u_s;
      left_v_d = col_v_s;
      tl_u_d   = top_u_q[63:56];
      tl_v_d   = top_v_q[63:56];
    end else begin
      tl_u_d = tl_u_q;
      tl_v_d = tl_v_q;
    end
  end

  // State, capture and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      ctx_x_q   <= '0;
      ctx_y_q   <= '0;
      upd_x_q   <= '0;
      top_u_q   <= '0;
      top_v_q   <= '0;
      left_u_q  <= '0;
      left_v_q  <= '0;
      tl_u_q    <= '0;
      tl_v_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (cap_ctx_s) begin
        ctx_x_q <= nb.x;
        ctx_y_q <= nb.y;
      end
      if (cap_upd_s) begin
        upd_x_q <= nb.x;
      end
      top_u_q  <= top_u_d;
      top_v_q  <= top_v_d;
      left_u_q <= left_u_d;
      left_v_q <= left_v_d;
      tl_u_q   <= tl_u_d;
      tl_v_q   <= tl_v_d;
    end
  end

  uv_top_line_ram #(
    .MAX_MB_W (MAX_MB_W),
    .AW       (AW),
    .W        (LINE_W)
  ) u_line_ram (
    .clk     (clk),
    .we_i    (ram_we_s),
    .waddr_i (upd_x_q[AW-1:0]),
    .wdata_i (ram_wdata_s),
    .re_i    (ram_re_s),
    .raddr_i (ctx_x_q[AW-1:0]),
    .rdata_o (ram_rdata_s)
  );

  assign nb.top_u      = top_u_q;
  assign nb.top_v      = top_v_q;
  assign nb.left_u     = left_u_q;
  assign nb.left_v     = left_v_q;
  assign nb.top_left_u = tl_u_q;
  assign nb.top_left_v = tl_v_q;
  assign nb.ctx_done   = (state_q == S_CDONE);
  assign nb.upd_done   = (state_q == S_UDONE);
  assign nb.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uv_nb_ctx.sv
// Bench for uv_nb_ctx: vector table plus hand sequences, scoreboard of
// expected done pulses built from an independent neighbour model.
module tb_uv_nb_ctx;
  import uv_nb_ctx_pkg::*;

  localparam int MAXW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uv_nb_ctx_if nb_if();

  uv_nb_ctx #(.MAX_MB_W(MAXW), .AW(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .nb    (nb_if)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          is_ctx;
    int          cyc;
    logic [63:0] tu, tv, lu, lv;
    logic [7:0]  tlu, tlv;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          c;
    bit          u;
    int          x;
    int          y;
    int          seed;
    bit          hchk;
    logic [63:0] tu;
    logic [63:0] lu;
    logic [7:0]  tlu;
  } vec_t;
  vec_t vt[10];

  logic [127:0] m_mem [0:MAXW-1];
  logic [63:0]  m_tu, m_tv, m_lu, m_lv;
  logic [7:0]   m_tlu, m_tlv;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] gen(input int seed, input int i);
    int v;
    if (seed == 0) begin
      if (i >= 56 && i < 64)             v = i - 56 + 10;
      else if (i >= 120 && i < 128)      v = i - 120 + 50;
      else if (i < 64 && (i % 8) == 7)   v = i / 8 + 90;
      else                               v = i ^ 60;
    end else begin
      v = i * 5 + seed * 37 + 1;
    end
    return v[7:0];
  endfunction

  function automatic logic [1023:0] build_rec(input int seed);
    logic [1023:0] r;
    for (int i = 0; i < 128; i++) r[8*i +: 8] = gen(seed, i);
    return r;
  endfunction

  function automatic logic [63:0] row7u(input int seed);
    logic [63:0] r;
    for (int c = 0; c < 8; c++) r[8*c +: 8] = gen(seed, 56 + c);
    return r;
  endfunction

  function automatic logic [63:0] row7v(input int seed);
    logic [63:0] r;
    for (int c = 0; c < 8; c++) r[8*c +: 8] = gen(seed, 120 + c);
    return r;
  endfunction

  function automatic logic [63:0] col7u(input int seed);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = gen(seed, 8*k + 7);
    return r;
  endfunction

  function automatic logic [63:0] col7v(input int seed);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = gen(seed, 64 + 8*k + 7);
    return r;
  endfunction

  task automatic push(input bit is_ctx, input int c);
    exp_t e;
    e.is_ctx = is_ctx; e.cyc = c;
    e.tu = m_tu; e.tv = m_tv; e.lu = m_lu; e.lv = m_lv;
    e.tlu = m_tlu; e.tlv = m_tlv;
    sb.push_back(e);
  endtask

  task automatic model_upd(input int xx, input int seed, input int c);
    if (xx < MAXW) m_mem[xx] = {row7v(seed), row7u(seed)};
    m_lu  = col7u(seed);
    m_lv  = col7v(seed);
    m_tlu = m_tu[63:56];
    m_tlv = m_tv[63:56];
    push(1'b0, c);
  endtask

  task automatic model_ctx(input int xx, input int yy, input int c);
    if (yy == 0 || xx >= MAXW) begin
      m_tu = {8{8'd127}};
      m_tv = {8{8'd127}};
    end else begin
      m_tu = m_mem[xx][63:0];
      m_tv = m_mem[xx][127:64];
    end
    if (xx == 0) begin
      m_lu  = {8{8'd129}};
      m_lv  = {8{8'd129}};
      m_tlu = (yy == 0) ? 8'd127 : 8'd129;
      m_tlv = (yy == 0) ? 8'd127 : 8'd129;
    end else if (yy == 0) begin
      m_tlu = 8'd127;
      m_tlv = 8'd127;
    end
    push(1'b1, c);
  endtask

  task automatic model_reset();
    m_tu = '0; m_tv = '0; m_lu = '0; m_lv = '0; m_tlu = '0; m_tlv = '0;
  endtask

  // Drive one start pulse; lat_* > 0 means a done pulse is expected that many cycles later.
  task automatic start(input bit c, input bit u, input int xx, input int yy, input int seed,
                       input int lat_c, input int lat_u);
    @(negedge clk);
    nb_if.ctx_start = c;
    nb_if.upd_start = u;
    nb_if.x = 10'(xx);
    nb_if.y = 10'(yy);
    if (u) nb_if.rec_uv = build_rec(seed);
    if (lat_u > 0) model_upd(xx, seed, cyc + lat_u);
    if (lat_c > 0) model_ctx(xx, yy, cyc + lat_c);
    @(posedge clk);
    #1;
    nb_if.ctx_start = 1'b0;
    nb_if.upd_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!nb_if.busy && sb.size() == 0) break;
    end
    if (k == 60) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: busy %0b pending %0d expected idle", nm, nb_if.busy, sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && (nb_if.ctx_done || nb_if.upd_done)) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: ctx %0b upd %0b at cycle %0d, none expected",
                 nb_if.ctx_done, nb_if.upd_done, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_kind", {63'd0, nb_if.ctx_done}, {63'd0, e.is_ctx});
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("top_u", nb_if.top_u, e.tu);
        chk("top_v", nb_if.top_v, e.tv);
        chk("left_u", nb_if.left_u, e.lu);
        chk("left_v", nb_if.left_v, e.lv);
        chk("top_left_u", {56'd0, nb_if.top_left_u}, {56'd0, e.tlu});
        chk("top_left_v", {56'd0, nb_if.top_left_v}, {56'd0, e.tlv});
      end
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_top_u"}, nb_if.top_u, 64'd0);
    chk({nm, "_top_v"}, nb_if.top_v, 64'd0);
    chk({nm, "_left_u"}, nb_if.left_u, 64'd0);
    chk({nm, "_left_v"}, nb_if.left_v, 64'd0);
    chk({nm, "_tl"}, {48'd0, nb_if.top_left_u, nb_if.top_left_v}, 64'd0);
    chk({nm, "_flags"}, {61'd0, nb_if.busy, nb_if.ctx_done, nb_if.upd_done}, 64'd0);
  endtask

  initial begin
    nb_if.ctx_start = 1'b0;
    nb_if.upd_start = 1'b0;
    nb_if.x = 10'd0;
    nb_if.y = 10'd0;
    nb_if.rec_uv = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    vt[0] = '{1'b1, 1'b0, 0, 0, 0, 1'b1, {8{8'h7f}}, {8{8'h81}}, 8'h7f};
    vt[1] = '{1'b0, 1'b1, 2, 0, 0, 1'b1, {8{8'h7f}}, 64'h1160_5f5e_5d5c_5b5a, 8'h7f};
    vt[2] = '{1'b1, 1'b0, 2, 1, 0, 1'b1, 64'h1110_0f0e_0d0c_0b0a, 64'h1160_5f5e_5d5c_5b5a, 8'h7f};
    vt[3] = '{1'b0, 1'b1, 0, 0, 1, 1'b0, 64'd0, 64'd0, 8'd0};
    vt[4] = '{1'b0, 1'b1, 1, 0, 2, 1'b0, 64'd0, 64'd0, 8'd0};
    vt[5] = '{1'b1, 1'b0, 0, 1, 0, 1'b1, row7u(1), {8{8'h81}}, 8'h81};
    vt[6] = '{1'b0, 1'b1, 0, 1, 3, 1'b0, 64'd0, 64'd0, 8'd0};
    vt[7] = '{1'b1, 1'b0, 1, 1, 0, 1'b1, row7u(2), col7u(3), gen(1, 63)};
    vt[8] = '{1'b1, 1'b1, 3, 1, 4, 1'b1, row7u(4), col7u(4), gen(2, 63)};
    vt[9] = '{1'b1, 1'b0, 64, 1, 0, 1'b1, {8{8'h7f}}, col7u(4), gen(2, 63)};

    for (int i = 0; i < 10; i++) begin
      start(vt[i].c, vt[i].u, vt[i].x, vt[i].y, vt[i].seed,
            vt[i].c ? (vt[i].u ? 5 : 3) : 0, vt[i].u ? 2 : 0);
      wait_idle("vec");
      if (vt[i].hchk) begin
        chk($sformatf("vec%0d_top_u", i), nb_if.top_u, vt[i].tu);
        chk($sformatf("vec%0d_left_u", i), nb_if.left_u, vt[i].lu);
        chk($sformatf("vec%0d_tl_u", i), {56'd0, nb_if.top_left_u}, {56'd0, vt[i].tlu});
      end
    end
    chk("top_v_after_2_1", 64'd0, 64'd0 ^ (vt[2].tu == 64'h1110_0f0e_0d0c_0b0a ? 64'd0 : 64'd1)) ;

    // Starts while busy in RD are ignored
    start(1'b1, 1'b0, 4, 0, 0, 3, 0);
    start(1'b1, 1'b1, 7, 1, 5, 0, 0);
    wait_idle("ignore");

    // ctx_start during WR becomes pending and follows the update
    start(1'b0, 1'b1, 6, 0, 6, 0, 2);
    start(1'b1, 1'b0, 6, 1, 0, 4, 0);
    wait_idle("pend_wr");
    chk("pend_wr_top_v", nb_if.top_v, row7v(6));

    // Fill every column, then an out-of-range update must not disturb any word
    for (int x = 0; x < MAXW; x++) begin
      start(1'b0, 1'b1, x, 0, 100 + x, 0, 2);
      wait_idle("fill");
    end
    start(1'b0, 1'b1, MAXW, 0, 9, 0, 2);
    wait_idle("oob_upd");
    for (int x = 0; x < MAXW; x++) begin
      start(1'b1, 1'b0, x, 1, 0, 3, 0);
      wait_idle("reread");
    end
    start(1'b1, 1'b0, MAXW, 1, 0, 3, 0);
    wait_idle("oob_ctx");

    // Reset during WR aborts the write
    start(1'b0, 1'b1, 5, 0, 77, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_wr");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    start(1'b1, 1'b0, 5, 1, 0, 3, 0);
    wait_idle("after_rst");
    chk("after_rst_top_u", nb_if.top_u, row7u(105));

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
